// File: rtl/ecg_window_loader_if.sv
// Bundles the sample stream, window hand-off and status signals of ecg_window_loader.
// slave = loader side, master = producer/consumer side.
interface ecg_window_loader_if #(
  parameter int N_SAMPLES = 187
);
  logic [7:0]             s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic                   flush;
  logic [8*N_SAMPLES-1:0] win_data;
  logic                   win_valid;
  logic                   win_ack;
  logic [7:0]             fill_cnt;
  logic [15:0]            win_total;

  modport slave (
    input  s_data, s_valid, flush, win_ack,
    output s_ready, win_data, win_valid, fill_cnt, win_total
  );

  modport master (
    output s_data, s_valid, flush, win_ack,
    input  s_ready, win_data, win_valid, fill_cnt, win_total
  );
endinterface

// File: rtl/ecg_window_loader.sv
// Shifts ECG samples into an N_SAMPLES-byte window and holds it until acked; 1-cycle win_valid latency,
// no samples taken while a window is held. Define WIN_OVERLAP_EN to keep N_SAMPLES-HOP samples across windows.
module ecg_window_loader #(
  parameter int N_SAMPLES = 187,
  parameter int HOP       = 94
) (
  input  logic                  clk,
  input  logic                  reset,
  ecg_window_loader_if.slave    bus
);

  typedef enum logic {FILL, FULL} state_t;

`ifdef WIN_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  localparam logic [7:0] LAST   = 8'(N_SAMPLES);
  localparam logic [7:0] RELOAD = OVERLAP ? 8'(N_SAMPLES - HOP) : 8'd0;

  state_t                 state_q, state_d;
  logic [7:0]             fill_q, fill_d;
  logic [15:0]            total_q, total_d;
  logic [8*N_SAMPLES-1:0] data_q;
  logic                   run_q;
  logic                   shift;

  // run_q keeps s_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      fill_q  <= 8'd0;
      total_q <= 16'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      total_q <= total_d;
      run_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (shift) begin
      data_q <= {data_q[8*N_SAMPLES-9:0], bus.s_data};
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    total_d = total_q;
    shift   = 1'b0;
    if (bus.flush) begin
      // flush outranks both a pending sample and an ack
      state_d = FILL;
      fill_d  = 8'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (run_q && bus.s_valid) begin
            shift  = 1'b1;
            fill_d = fill_q + 8'd1;
            if (fill_q + 8'd1 == LAST) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (bus.win_ack) begin
            state_d = FILL;
            total_d = total_q + 16'd1;
            fill_d  = RELOAD;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  assign bus.s_ready   = run_q && (state_q == FILL);
  assign bus.win_valid = (state_q == FULL);
  assign bus.win_data  = data_q;
  assign bus.fill_cnt  = fill_q;
  assign bus.win_total = total_q;

endmodule

// File: tb/tb_ecg_window_loader.sv
// Directed plus random stimulus for ecg_window_loader, checked each cycle against a sample-queue model.
// Build with +define+WIN_OVERLAP_EN to exercise overlap mode.
module tb_ecg_window_loader;
  localparam int N   = 187;
  localparam int HOP = 94;
`ifdef WIN_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ecg_window_loader_if #(.N_SAMPLES(N)) bus ();
  ecg_window_loader #(.N_SAMPLES(N), .HOP(HOP)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned q[$];
  bit m_run, m_full;
  int m_fill, m_total;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < N; i++) q.push_back(8'd0);
    m_run = 0; m_full = 0; m_fill = 0; m_total = 0;
  endfunction

  function automatic void model_step();
    if (!m_run) begin
      m_run = 1;
    end else if (bus.flush) begin
      m_fill = 0;
      m_full = 0;
    end else if (m_full) begin
      if (bus.win_ack) begin
        m_full  = 0;
        m_total = (m_total + 1) % 65536;
        m_fill  = OVL ? N - HOP : 0;
      end
    end else if (bus.s_valid) begin
      void'(q.pop_front());
      q.push_back(bus.s_data);
      m_fill++;
      if (m_fill == N) m_full = 1;
    end
  endfunction

  // byte i counted from bits [7:0] holds the i-th newest sample
  task automatic check_window(input string tag);
    int idx = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.win_data[8*i +: 8] !== q[N-1-i]) begin
        idx = i;
        break;
      end
    end
    check_eq($sformatf("%s_byte%0d", tag, idx), 32'(bus.win_data[8*idx +: 8]), 32'(q[N-1-idx]));
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_s_ready"},   32'(bus.s_ready),   32'(m_run && !m_full));
    check_eq({tag, "_win_valid"}, 32'(bus.win_valid), 32'(m_full));
    check_eq({tag, "_fill_cnt"},  32'(bus.fill_cnt),  32'(m_fill));
    check_eq({tag, "_win_total"}, 32'(bus.win_total), 32'(m_total));
    check_window(tag);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic a);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.flush   = f;
    bus.win_ack = a;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic feed(input int cnt, input string tag);
    for (int k = 0; k < cnt; k++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      tick(tag);
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int refill;
    int tv;
    refill = OVL ? HOP : N;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    model_reset();

    #12;
    check_all("in_reset");

    @(negedge clk);
    reset = 1'b1;
    tick("release");

    for (int k = 1; k <= N; k++) begin
      drive(1'b1, 8'(k), 1'b0, 1'b0);
      tick("stream1");
    end
    check_eq("w1_valid", 32'(bus.win_valid), 32'd1);
    check_eq("w1_top",   32'(bus.win_data[8*N-1 -: 8]), 32'h01);
    check_eq("w1_low",   32'(bus.win_data[7:0]), 32'hBB);
    check_eq("w1_ready", 32'(bus.s_ready), 32'd0);

    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      tick("hold");
    end
    check_eq("hold_top", 32'(bus.win_data[8*N-1 -: 8]), 32'h01);
    check_eq("hold_low", 32'(bus.win_data[7:0]), 32'hBB);

    drive(1'b0, 8'd0, 1'b0, 1'b1);
    tick("ack1");
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check_eq("ack1_total", 32'(bus.win_total), 32'd1);
    check_eq("ack1_ready", 32'(bus.s_ready), 32'd1);
    check_eq("ack1_fill",  32'(bus.fill_cnt), OVL ? 32'd93 : 32'd0);

    for (int k = 0; k < refill; k++) begin
      drive(1'b1, 8'(188 + k), 1'b0, 1'b0);
      tick("stream2");
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check_eq("w2_valid", 32'(bus.win_valid), 32'd1);
    check_eq("w2_top",   32'(bus.win_data[8*N-1 -: 8]), OVL ? 32'h5F : 32'hBC);
    check_eq("w2_low",   32'(bus.win_data[7:0]), OVL ? 32'h19 : 32'h76);
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    tick("ack2");

    drive(1'b0, 8'd0, 1'b1, 1'b0);
    tick("flush0");
    feed(50, "pre_flush");
    check_eq("pre_flush_fill", 32'(bus.fill_cnt), 32'd50);
    tv = m_total;
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    tick("flush");
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check_eq("flush_fill",  32'(bus.fill_cnt), 32'd0);
    check_eq("flush_total", 32'(bus.win_total), 32'(tv));
    check_eq("flush_drop",  32'(bus.win_data[7:0]), 32'(q[N-1]));

    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 49) == 0,
            $urandom_range(0, 4) == 0);
      tick("rand");
    end

    drive(1'b0, 8'd0, 1'b1, 1'b0);
    tick("pre_rst_flush");
    feed(120, "pre_rst");
    check_eq("pre_rst_fill", 32'(bus.fill_cnt), 32'd120);
    tick("pre_rst_idle");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check_eq("async_rst_top", 32'(bus.win_data[8*N-1 -: 8]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick("release2");
    feed(N - 1, "refill");
    check_eq("refill_short", 32'(bus.win_valid), 32'd0);
    feed(1, "refill_last");
    check_eq("refill_full", 32'(bus.win_valid), 32'd1);
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    tick("ack3");
    drive(1'b0, 8'd0, 1'b0, 1'b0);

    @(negedge clk);
    force dut.total_q = 16'hFFFF;
    #1;
    release dut.total_q;
    m_total = 16'hFFFF;
    feed(OVL ? HOP : N, "wrap_fill");
    check_eq("wrap_pre", 32'(bus.win_total), 32'hFFFF);
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    tick("wrap_ack");
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check_eq("wrap_total", 32'(bus.win_total), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
